// File: rtl/mini_alu_add_seq.sv
// mini_alu_add_seq: multi-cycle WIDTH-bit adder/subtractor that processes
// CHUNK bits per clock, with unsigned/signed overflow detection, optional
// saturation and valid/ready handshakes on both sides.
module mini_alu_add_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             sub,
    input  logic             sgn,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             carry
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Control and output state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             sgn_q, sgn_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    // Operand and partial-result datapath (no reset needed)
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;

    // Per-chunk arithmetic
    int               lsb;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] raw;
    logic             ovf_calc;

    // Saturation value for the active mode; a_msb gives the sign of the
    // true signed result when signed overflow has occurred.
    function automatic logic [WIDTH-1:0] sat_value(input logic s_sgn,
                                                   input logic s_sub,
                                                   input logic a_msb);
        logic [WIDTH-1:0] v;
        if (s_sgn) begin
            v      = a_msb ? '0 : '1;
            v[MSB] = a_msb;
        end else begin
            v = s_sub ? '0 : '1;
        end
        return v;
    endfunction

    // Chunk adder plus the flag logic that only matters on the last chunk
    always_comb begin
        lsb       = int'(cnt_q) * CHUNK;
        a_chunk   = a_q[lsb +: CHUNK];
        b_chunk   = b_q[lsb +: CHUNK];
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        raw       = res_q;
        raw[lsb +: CHUNK] = chunk_sum[CHUNK-1:0];
        if (sgn_q) begin
            ovf_calc = (a_q[MSB] == b_q[MSB]) && (raw[MSB] != a_q[MSB]);
        end else begin
            // Subtraction carry-out of 0 means a borrow occurred
            ovf_calc = sub_q ? ~chunk_sum[CHUNK] : chunk_sum[CHUNK];
        end
    end

    // Next-state logic: accept in IDLE, one chunk per clock in RUN,
    // hold the result in DONE until the consumer takes it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        sgn_d   = sgn_q;
        sat_d   = sat_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = data0;
                    b_d     = sub ? ~data1 : data1;
                    carry_d = sub;
                    sub_d   = sub;
                    sgn_d   = sgn;
                    sat_d   = sat;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = raw;
                carry_d = chunk_sum[CHUNK];
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    ovf_d   = ovf_calc;
                    cout_d  = chunk_sum[CHUNK];
                    sum_d   = (sat_q && ovf_calc) ? sat_value(sgn_q, sub_q, a_q[MSB]) : raw;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and visible result registers, cleared by async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            sgn_q   <= 1'b0;
            sat_q   <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            sgn_q   <= sgn_d;
            sat_q   <= sat_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
        end
    end

    // Operand and partial-result registers, always rewritten before use
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign overflow  = ovf_q;
    assign carry     = cout_q;

endmodule
